// File: rtl/euler_writeback_buffer.sv
// euler_writeback_buffer: captures join/multiply results into a small FIFO and
// drains them to the state-RAM write port under a busy/stall handshake.
// The head entry is held in the registered ram_* output and counts toward occupancy.
// Optional feature macro: WB_ADDR_CHECK_EN (sequential-address checking, drives seq_error).
module euler_writeback_buffer #(
  parameter int unsigned ADD_SIZE  = 16,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [ADD_SIZE-1:0]  in_addr,
  input  logic                 in_overflow,
  input  logic [ADD_SIZE-1:0]  expected_count,
  input  logic                 ram_busy,
  output logic                 ram_we,
  output logic [ADD_SIZE-1:0]  ram_addr,
  output logic [DATA_SIZE-1:0] ram_data,
  output logic                 full,
  output logic                 empty,
  output logic [ADD_SIZE-1:0]  write_count,
  output logic                 run_done,
  output logic                 overflow_sticky,
  output logic                 drop_error,
  output logic                 seq_error
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADD_SIZE-1:0]  addr;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     q_cnt_q, q_cnt_d;
  logic                 ram_we_q, ram_we_d;
  logic [ADD_SIZE-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_SIZE-1:0] ram_data_q, ram_data_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic [ADD_SIZE-1:0]  write_count_q, write_count_d;
  logic                 run_done_q, run_done_d;
  logic                 ovf_q, ovf_d, drop_q, drop_d;

  logic                 commit, accept, hit_expected, push_en, pop_en;
  logic [CNT_W-1:0]     occ, occ_d;
  entry_t               in_entry, head_entry;

  assign in_entry   = '{addr: in_addr, data: in_data};
  assign head_entry = mem_q[rd_ptr_q];

  // Next-state, queue control and output-register load decisions
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    q_cnt_d       = q_cnt_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_data_d    = ram_data_q;
    write_count_d = write_count_q;
    ovf_d         = ovf_q;
    drop_d        = drop_q;
    push_en       = 1'b0;
    pop_en        = 1'b0;

    commit       = ram_we_q & ~ram_busy;
    occ          = q_cnt_q + CNT_W'(ram_we_q);
    hit_expected = (expected_count != '0) &&
                   ((write_count_q + ADD_SIZE'(1)) == expected_count);
    accept       = in_valid && (state_q != DONE) &&
                   ((occ < CNT_W'(DEPTH)) || commit);

    if (accept)              ovf_d  = ovf_q | in_overflow;
    if (in_valid && !accept) drop_d = 1'b1;
    if (commit)              write_count_d = write_count_q + ADD_SIZE'(1);

    if (commit && hit_expected) begin
      // Final write of the run: stop issuing, anything queued stays put
      ram_we_d = 1'b0;
      state_d  = DONE;
      push_en  = accept;
    end else if (commit) begin
      if (q_cnt_q != '0) begin
        pop_en     = 1'b1;
        ram_addr_d = head_entry.addr;
        ram_data_d = head_entry.data;
        ram_we_d   = 1'b1;
        push_en    = accept;
      end else if (accept) begin
        ram_addr_d = in_addr;
        ram_data_d = in_data;
        ram_we_d   = 1'b1;
      end else begin
        ram_we_d = 1'b0;
        state_d  = IDLE;
      end
    end else if (!ram_we_q) begin
      if (accept) begin
        ram_addr_d = in_addr;
        ram_data_d = in_data;
        ram_we_d   = 1'b1;
        state_d    = WRITE;
      end
    end else begin
      push_en = accept;
    end

    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    q_cnt_d = q_cnt_q + CNT_W'(push_en) - CNT_W'(pop_en);

    occ_d      = q_cnt_d + CNT_W'(ram_we_d);
    full_d     = (occ_d == CNT_W'(DEPTH));
    empty_d    = (occ_d == '0);
    run_done_d = (state_d == DONE);
  end

  // Control and output registers; clear behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      q_cnt_q       <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      write_count_q <= '0;
      run_done_q    <= 1'b0;
      ovf_q         <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      q_cnt_q       <= q_cnt_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_q    <= ram_data_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      write_count_q <= write_count_d;
      run_done_q    <= run_done_d;
      ovf_q         <= ovf_d;
      drop_q        <= drop_d;
    end
  end

  // Queue storage behind the output register; contents need no reset
  always_ff @(posedge clk) begin
    if (push_en && !(rst || clear)) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

`ifdef WB_ADDR_CHECK_EN
  logic [ADD_SIZE-1:0] last_addr_q, last_addr_d;
  logic                have_last_q, have_last_d;
  logic                seq_q, seq_d;

  // Each accepted address must follow the previous accepted one
  always_comb begin
    last_addr_d = last_addr_q;
    have_last_d = have_last_q;
    seq_d       = seq_q;
    if (accept) begin
      if (have_last_q && (in_addr != (last_addr_q + ADD_SIZE'(1)))) seq_d = 1'b1;
      last_addr_d = in_addr;
      have_last_d = 1'b1;
    end
  end

  // Address tracking registers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      last_addr_q <= '0;
      have_last_q <= 1'b0;
      seq_q       <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      have_last_q <= have_last_d;
      seq_q       <= seq_d;
    end
  end

  assign seq_error = seq_q;
`else
  assign seq_error = 1'b0;
`endif

  assign ram_we          = ram_we_q;
  assign ram_addr        = ram_addr_q;
  assign ram_data        = ram_data_q;
  assign full            = full_q;
  assign empty           = empty_q;
  assign write_count     = write_count_q;
  assign run_done        = run_done_q;
  assign overflow_sticky = ovf_q;
  assign drop_error      = drop_q;

endmodule

// File: tb/tb_euler_writeback_buffer.sv
// Testbench for euler_writeback_buffer: scoreboard of expected RAM writes,
// one task per scenario.
module tb_euler_writeback_buffer;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_overflow, ram_busy;
  logic [15:0] in_data, in_addr, expected_count;
  logic        ram_we, full, empty, run_done, overflow_sticky, drop_error, seq_error;
  logic [15:0] ram_addr, ram_data, write_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];

`ifdef WB_ADDR_CHECK_EN
  logic exp_seq = 1'b1;
`else
  logic exp_seq = 1'b0;
`endif

  euler_writeback_buffer #(.ADD_SIZE(16), .DATA_SIZE(16), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr), .in_overflow(in_overflow),
    .expected_count(expected_count), .ram_busy(ram_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .full(full), .empty(empty), .write_count(write_count), .run_done(run_done),
    .overflow_sticky(overflow_sticky), .drop_error(drop_error), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  // Commit monitor: a write happens at the next rising edge when ram_we && !ram_busy
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && !clear && ram_we && !ram_busy) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, none expected", ram_addr, ram_data);
      end else begin
        e = sb.pop_front();
        if ({ram_addr, ram_data} !== e) begin
          bad++;
          $display("FAIL write_order: got addr=%h data=%h, want addr=%h data=%h",
                   ram_addr, ram_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] d, input logic ovf, input bit acc);
    in_valid = 1'b1; in_addr = a; in_data = d; in_overflow = ovf;
    if (acc) sb.push_back({a, d});
    tick(1);
    in_valid = 1'b0; in_overflow = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_addr = 16'hdead; in_data = 16'hbeef;
    tick(2);
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || !empty) && n < max_cycles) begin
      tick(1);
      n++;
    end
    total++;
    if (sb.size() != 0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d empty=%b, want pending=0 empty=1", name, sb.size(), empty);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ram_we, ram_addr, ram_data, full, empty, write_count} !== {1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL reset_datapath: we=%b addr=%h data=%h full=%b empty=%b wc=%0d, want 0 0 0 0 1 0",
               ram_we, ram_addr, ram_data, full, empty, write_count);
    end
    total++;
    if ({run_done, overflow_sticky, drop_error, seq_error} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: done/ovf/drop/seq=%b%b%b%b, want 0000",
               run_done, overflow_sticky, drop_error, seq_error);
    end
  endtask

  task automatic test_basic();
    logic [15:0] a [3];
    logic [15:0] d [3];
    a = '{16'h0011, 16'h0012, 16'h0013};
    d = '{16'h0100, 16'h0200, 16'h0300};
    do_reset();
    expected_count = 16'd3; ram_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(a[i], d[i], 1'b0, 1'b1);
      total++;
      if ({ram_we, ram_addr, ram_data} !== {1'b1, a[i], d[i]}) begin
        bad++;
        $display("FAIL basic_latency%0d: we=%b addr=%h data=%h, want 1 %h %h", i, ram_we, ram_addr, ram_data, a[i], d[i]);
      end
      tick(1);
      total++;
      if (ram_we !== 1'b0 || write_count !== 16'(i + 1)) begin
        bad++;
        $display("FAIL basic_single%0d: we=%b wc=%0d, want 0 %0d", i, ram_we, write_count, i + 1);
      end
      if (i < 2) tick(1);
    end
    total++;
    if (run_done !== 1'b1) begin
      bad++;
      $display("FAIL basic_done: run_done=%b, want 1", run_done);
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    expected_count = 16'd0; ram_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 16'ha000 + 16'(i), 1'b0, i < 4);
    total++;
    if ({full, drop_error, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL full_drop: full=%b drop=%b we=%b addr=%h, want 1 1 1 0100", full, drop_error, ram_we, ram_addr);
    end
    ram_busy = 1'b0;
    drain("full_drop", 10);
    total++;
    if (write_count !== 16'd4) begin
      bad++;
      $display("FAIL full_drop_count: wc=%0d, want 4", write_count);
    end
  endtask

  task automatic test_full_commit_push();
    do_reset();
    expected_count = 16'd0; ram_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(16'h0200 + 16'(i), 16'hb000 + 16'(i), 1'b0, 1'b1);
    ram_busy = 1'b0;
    send(16'h0204, 16'hb004, 1'b0, 1'b1);
    total++;
    if ({full, drop_error} !== 2'b10) begin
      bad++;
      $display("FAIL full_commit_push: full=%b drop=%b, want 1 0", full, drop_error);
    end
    drain("full_commit_push", 10);
    total++;
    if (write_count !== 16'd5) begin
      bad++;
      $display("FAIL full_commit_count: wc=%0d, want 5", write_count);
    end
  endtask

  task automatic test_overflow_clear();
    do_reset();
    expected_count = 16'd0; ram_busy = 1'b0;
    send(16'h0300, 16'h1111, 1'b0, 1'b1);
    tick(1);
    ram_busy = 1'b1;
    send(16'h0301, 16'h2222, 1'b0, 1'b1);
    total++;
    if (overflow_sticky !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: ovf=%b, want 0", overflow_sticky);
    end
    send(16'h0302, 16'h3333, 1'b1, 1'b1);
    tick(2);
    total++;
    if ({overflow_sticky, write_count} !== {1'b1, 16'd1}) begin
      bad++;
      $display("FAIL ovf_sticky: ovf=%b wc=%0d, want 1 1", overflow_sticky, write_count);
    end
    clear = 1'b1; in_valid = 1'b1; in_addr = 16'h0999; in_data = 16'h9999;
    tick(1);
    clear = 1'b0; in_valid = 1'b0;
    sb.delete();
    total++;
    if ({ram_we, empty, write_count, overflow_sticky} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
      bad++;
      $display("FAIL clear: we=%b empty=%b wc=%0d ovf=%b, want 0 1 0 0", ram_we, empty, write_count, overflow_sticky);
    end
    ram_busy = 1'b0;
  endtask

  task automatic test_addr_seq();
    do_reset();
    expected_count = 16'd0; ram_busy = 1'b0;
    send(16'h0005, 16'h0055, 1'b0, 1'b1);
    send(16'h0006, 16'h0066, 1'b0, 1'b1);
    total++;
    if (seq_error !== 1'b0) begin
      bad++;
      $display("FAIL seq_early: seq=%b, want 0", seq_error);
    end
    send(16'h0008, 16'h0088, 1'b0, 1'b1);
    total++;
    if (seq_error !== exp_seq) begin
      bad++;
      $display("FAIL seq_gap: seq=%b, want %b", seq_error, exp_seq);
    end
    drain("addr_seq", 10);
    total++;
    if (write_count !== 16'd3) begin
      bad++;
      $display("FAIL seq_count: wc=%0d, want 3", write_count);
    end
  endtask

  task automatic test_done_drop();
    do_reset();
    expected_count = 16'd1; ram_busy = 1'b0;
    send(16'h0400, 16'h4444, 1'b0, 1'b1);
    tick(1);
    total++;
    if ({run_done, ram_we, drop_error} !== 3'b100) begin
      bad++;
      $display("FAIL done_state: done=%b we=%b drop=%b, want 1 0 0", run_done, ram_we, drop_error);
    end
    send(16'h0401, 16'h5555, 1'b0, 1'b0);
    tick(1);
    total++;
    if ({run_done, ram_we, drop_error, write_count} !== {3'b101, 16'd1}) begin
      bad++;
      $display("FAIL done_drop: done=%b we=%b drop=%b wc=%0d, want 1 0 1 1",
               run_done, ram_we, drop_error, write_count);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_overflow = 1'b0;
    in_data = '0; in_addr = '0; expected_count = '0; ram_busy = 1'b0;
    tick(1);
    test_reset();
    test_basic();
    test_full_drop();
    test_full_commit_push();
    test_overflow_clear();
    test_addr_seq();
    test_done_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
